// File: rtl/gerador_requisicoes_pkg.sv
// Shared types and constants for the station request generator.
// Holds the FSM encoding, station IDs, the request record and helper functions.
package gerador_requisicoes_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OFFER = 1'b1
  } state_t;

  localparam logic STATION_0    = 1'b0;
  localparam logic STATION_1    = 1'b1;
  localparam int   NUM_STATIONS = 2;

  typedef struct packed {
    logic       id;
    logic [3:0] hh;
    logic [1:0] b;
  } req_t;

  function automatic int cnt_width(input int db_cycles);
    return $clog2(db_cycles + 1);
  endfunction

  // A lone pending slot wins; a tie goes to the station that was not served last.
  function automatic logic pick_station(input logic [1:0] pend, input logic last);
    logic id;
    if (pend == 2'b11) begin
      id = ~last;
    end else if (pend[1]) begin
      id = STATION_1;
    end else begin
      id = STATION_0;
    end
    return id;
  endfunction

endpackage

// File: rtl/gerador_requisicoes_debounce_botao.sv
// One button bit: 2-FF synchronizer followed by a debouncer that only flips
// after DB_CYCLES consecutive cycles of disagreement with the synchronized input.
module debounce_botao
  import gerador_requisicoes_pkg::*;
#(
  parameter int DB_CYCLES = 16
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic raw_i,
  output logic deb_o
);

  localparam int            CW       = cnt_width(DB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic          meta_q;
  logic          sync_q;
  logic          deb_q;
  logic          deb_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Any cycle where the input agrees with the debounced value restarts the count.
  always_comb begin
    cnt_d = '0;
    deb_d = deb_q;
    if (sync_q != deb_q) begin
      if (cnt_q == CNT_LAST) begin
        deb_d = sync_q;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      deb_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      meta_q <= raw_i;
      sync_q <= meta_q;
      deb_q  <= deb_d;
      cnt_q  <= cnt_d;
    end
  end

  assign deb_o = deb_q;

endmodule

// File: rtl/gerador_requisicoes.sv
// Front end for the access-control datapath: turns debounced button presses into
// one-shot requests, holds one per station and offers them over valid/ready.
module gerador_requisicoes
  import gerador_requisicoes_pkg::*;
#(
  parameter int DB_CYCLES = 16
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic [3:0] hh0_i,
  input  logic [3:0] hh1_i,
  input  logic [1:0] b0_i,
  input  logic [1:0] b1_i,
  input  logic       req_ready_i,
  output logic       req_valid_o,
  output logic       req_id_o,
  output logic [3:0] req_hh_o,
  output logic [1:0] req_b_o,
  output logic [1:0] pend_o,
  output logic [1:0] drop_o
);

  logic [3:0] raw_btn;
  logic [3:0] deb_btn;
  logic [7:0] hh_raw;
  logic [7:0] hh_synced;
  logic [1:0] press_now;
  logic [1:0] press_prev_q;
  logic [1:0] press_evt;

  logic [1:0] pend_q;
  logic [1:0] pend_d;
  logic [1:0] drop_q;
  logic [1:0] drop_d;
  req_t       slot_q [NUM_STATIONS];
  req_t       slot_d [NUM_STATIONS];

  state_t     state_q;
  logic       req_valid_q;
  logic       last_q;
  req_t       out_q;
  logic       grant_id;
  logic       load;
  logic [1:0] drained;

  assign raw_btn = {b1_i, b0_i};
  assign hh_raw  = {hh1_i, hh0_i};

  genvar gi;
  for (gi = 0; gi < 4; gi++) begin : g_deb
    debounce_botao #(
      .DB_CYCLES(DB_CYCLES)
    ) u_deb (
      .clk_i  (clk_i),
      .rst_n_i(rst_n_i),
      .raw_i  (raw_btn[gi]),
      .deb_o  (deb_btn[gi])
    );
  end

  // Switch words are static, so a plain 2-FF synchronizer is enough.
  for (gi = 0; gi < NUM_STATIONS; gi++) begin : g_station
    logic [3:0] meta_q;
    logic [3:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        meta_q <= '0;
        sync_q <= '0;
      end else begin
        meta_q <= hh_raw[4*gi +: 4];
        sync_q <= meta_q;
      end
    end

    assign hh_synced[4*gi +: 4] = sync_q;
    assign press_now[gi]        = |deb_btn[2*gi +: 2];
  end

  // Only the 00 -> nonzero transition counts; adding a second button while held does not.
  assign press_evt = press_now & ~press_prev_q;

  assign grant_id = pick_station(pend_q, last_q);
  assign load     = (|pend_q) && ((state_q == ST_IDLE) || req_ready_i);
  assign drained  = load ? (grant_id ? 2'b10 : 2'b01) : 2'b00;

  // A press landing on the cycle its slot is drained refills the slot instead of dropping.
  always_comb begin
    pend_d = pend_q;
    drop_d = '0;
    slot_d = slot_q;
    for (int k = 0; k < NUM_STATIONS; k++) begin
      if (drained[k]) begin
        pend_d[k] = 1'b0;
      end
      if (press_evt[k]) begin
        if (!pend_q[k] || drained[k]) begin
          slot_d[k] = '{id: 1'(k), hh: hh_synced[4*k +: 4], b: deb_btn[2*k +: 2]};
          pend_d[k] = 1'b1;
        end else begin
          drop_d[k] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pend_q       <= '0;
      drop_q       <= '0;
      press_prev_q <= '0;
      for (int k = 0; k < NUM_STATIONS; k++) begin
        slot_q[k] <= '0;
      end
    end else begin
      pend_q       <= pend_d;
      drop_q       <= drop_d;
      press_prev_q <= press_now;
      slot_q       <= slot_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_IDLE;
      req_valid_q <= 1'b0;
      out_q       <= '0;
      last_q      <= STATION_1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (load) begin
            out_q       <= slot_q[grant_id];
            last_q      <= grant_id;
            req_valid_q <= 1'b1;
            state_q     <= ST_OFFER;
          end
        end
        ST_OFFER: begin
          if (req_ready_i) begin
            if (load) begin
              out_q  <= slot_q[grant_id];
              last_q <= grant_id;
            end else begin
              req_valid_q <= 1'b0;
              state_q     <= ST_IDLE;
            end
          end
        end
      endcase
    end
  end

  assign req_valid_o = req_valid_q;
  assign req_id_o    = out_q.id;
  assign req_hh_o    = out_q.hh;
  assign req_b_o     = out_q.b;
  assign pend_o      = pend_q;
  assign drop_o      = drop_q;

endmodule
